// File: rtl/pwm_duty_ramp.sv
// Soft-start/soft-stop duty slew limiter that feeds the PWM generator's 16-bit duty input.
// Duty moves toward the effective target by at most STEP counts once per PWM period.
module pwm_duty_ramp #(
    parameter int unsigned PERIOD   = 24000,
    parameter int unsigned STEP     = 240,
    parameter int unsigned MAX_DUTY = 24000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] target_i,
    output logic [15:0] duty_o,
    output logic        tick_o,
    output logic        atTarget_o,
    output logic        busy_o
);

    localparam logic [15:0] LAST_COUNT = 16'(PERIOD - 1);
    localparam logic [15:0] STEP_W     = 16'(STEP);
    localparam logic [15:0] MAX_W      = 16'(MAX_DUTY);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } rampState_t;

    rampState_t  stateQ;
    logic [15:0] cntQ, cntD;
    logic [15:0] targetQ, targetD;
    logic [15:0] dutyQ, dutyD;
    logic        tickQ, tickD;
    logic        atTargetQ;
    logic        busyQ;

    logic [15:0] effTarget;
    logic [15:0] clampedTarget;
    logic [15:0] gapUp, gapDown;

    assign effTarget     = enable_i ? targetQ : 16'd0;
    assign clampedTarget = (target_i > MAX_W) ? MAX_W : target_i;

    // Each gap is only used when it is positive, so the 16-bit subtraction never wraps
    // and dutyQ + STEP can only be chosen when it stays strictly below the target.
    assign gapUp   = effTarget - dutyQ;
    assign gapDown = dutyQ - effTarget;

    always_comb begin
        cntD    = (cntQ == LAST_COUNT) ? 16'd0 : cntQ + 16'd1;
        tickD   = (cntD == LAST_COUNT);
        targetD = load_i ? clampedTarget : targetQ;
        dutyD   = dutyQ;
        if (tickQ) begin
            if (dutyQ < effTarget) begin
                dutyD = (gapUp <= STEP_W) ? effTarget : dutyQ + STEP_W;
            end else if (dutyQ > effTarget) begin
                dutyD = (gapDown <= STEP_W) ? effTarget : dutyQ - STEP_W;
            end
        end
    end

    // The tick register is loaded from the next count, so it is high exactly while the
    // counter sits at its last value; the duty update therefore sees the pre-load target.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cntQ      <= 16'd0;
            targetQ   <= 16'd0;
            dutyQ     <= 16'd0;
            tickQ     <= 1'b0;
            atTargetQ <= 1'b1;
            busyQ     <= 1'b0;
            stateQ    <= OFF;
        end else begin
            cntQ      <= cntD;
            targetQ   <= targetD;
            dutyQ     <= dutyD;
            tickQ     <= tickD;
            atTargetQ <= (dutyQ == effTarget);
            case (stateQ)
                OFF: begin
                    if (effTarget != 16'd0) begin
                        stateQ <= RAMP;
                        busyQ  <= 1'b1;
                    end
                end
                RAMP: begin
                    if (dutyQ == effTarget && effTarget != 16'd0) begin
                        stateQ <= HOLD;
                        busyQ  <= 1'b0;
                    end else if (dutyQ == 16'd0 && effTarget == 16'd0) begin
                        stateQ <= OFF;
                        busyQ  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (dutyQ != effTarget) begin
                        stateQ <= RAMP;
                        busyQ  <= 1'b1;
                    end
                end
                default: begin
                    stateQ <= OFF;
                    busyQ  <= 1'b0;
                end
            endcase
        end
    end

    assign duty_o     = dutyQ;
    assign tick_o     = tickQ;
    assign atTarget_o = atTargetQ;
    assign busy_o     = busyQ;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a short period so a full soft start/stop fits
// in a few hundred cycles; every expected value below is worked out by hand.
module tb_pwm_duty_ramp;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] target;
    logic [15:0] duty;
    logic        tick;
    logic        atTarget;
    logic        busy;

    int total;
    int bad;
    int cycle;

    pwm_duty_ramp #(
        .PERIOD  (10),
        .STEP    (100),
        .MAX_DUTY(1000)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .enable_i  (enable),
        .load_i    (load),
        .target_i  (target),
        .duty_o    (duty),
        .tick_o    (tick),
        .atTarget_o(atTarget),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check is counted here and mismatches are reported.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s (cycle %0d): got %0d expected %0d", tag, cycle, observed, expected);
        end
    endtask

    // Advances one clock and leaves time 1 unit past the edge for driving and sampling.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic waitUntil(input int c);
        while (cycle < c) step();
    endtask

    // One-cycle load strobe issued in the current cycle.
    task automatic applyStimulus(input logic [15:0] value);
        load   = 1'b1;
        target = value;
        step();
        load   = 1'b0;
        target = 16'd0;
    endtask

    // Reset is held for the current cycle; the cycle after the edge becomes cycle 0.
    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle = 0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cycle  = 0;
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        target = 16'd0;
        @(posedge clk);
        #1;
        pulseReset();

        checkOutput("rst duty", int'(duty), 0);
        checkOutput("rst tick", int'(tick), 0);
        checkOutput("rst atTarget", int'(atTarget), 1);
        checkOutput("rst busy", int'(busy), 0);

        // Soft start to 350.
        enable = 1'b1;
        waitUntil(2);
        applyStimulus(16'd350);
        waitUntil(8);
        checkOutput("no early tick", int'(tick), 0);
        waitUntil(9);
        checkOutput("first tick", int'(tick), 1);
        checkOutput("duty before tick", int'(duty), 0);
        waitUntil(10);
        checkOutput("up 100", int'(duty), 100);
        checkOutput("tick one cycle", int'(tick), 0);
        checkOutput("busy ramp up", int'(busy), 1);
        checkOutput("not at target", int'(atTarget), 0);
        waitUntil(19);
        checkOutput("second tick", int'(tick), 1);
        waitUntil(20);
        checkOutput("up 200", int'(duty), 200);
        waitUntil(30);
        checkOutput("up 300", int'(duty), 300);
        waitUntil(40);
        checkOutput("up 350", int'(duty), 350);
        waitUntil(41);
        checkOutput("hold busy", int'(busy), 0);
        checkOutput("hold atTarget", int'(atTarget), 1);

        // Soft stop.
        enable = 1'b0;
        waitUntil(50);
        checkOutput("down 250", int'(duty), 250);
        checkOutput("stop busy", int'(busy), 1);
        waitUntil(60);
        checkOutput("down 150", int'(duty), 150);
        waitUntil(70);
        checkOutput("down 50", int'(duty), 50);
        checkOutput("stop busy late", int'(busy), 1);
        waitUntil(80);
        checkOutput("down 0", int'(duty), 0);
        waitUntil(81);
        checkOutput("off busy", int'(busy), 0);
        checkOutput("off atTarget", int'(atTarget), 1);

        // Oversized target clamps to MAX_DUTY.
        enable = 1'b1;
        applyStimulus(16'd5000);
        for (int k = 1; k <= 10; k++) begin
            waitUntil(80 + 10 * k);
            checkOutput($sformatf("clamp climb %0d", k), int'(duty), 100 * k);
        end
        waitUntil(190);
        checkOutput("clamp no overshoot", int'(duty), 1000);
        checkOutput("clamp hold busy", int'(busy), 0);

        // Bring duty down to 400, then reverse mid-period while ramping up.
        applyStimulus(16'd400);
        waitUntil(250);
        checkOutput("down to 400", int'(duty), 400);
        waitUntil(251);
        applyStimulus(16'd1000);
        waitUntil(255);
        applyStimulus(16'd250);
        waitUntil(260);
        checkOutput("reverse 300", int'(duty), 300);
        waitUntil(270);
        checkOutput("reverse 250", int'(duty), 250);
        waitUntil(271);
        checkOutput("reverse hold", int'(busy), 0);

        // Load coinciding with a tick only takes effect at the following tick.
        applyStimulus(16'd200);
        waitUntil(280);
        checkOutput("settle 200", int'(duty), 200);
        waitUntil(289);
        checkOutput("tick at load", int'(tick), 1);
        applyStimulus(16'd600);
        checkOutput("tick uses old target", int'(duty), 200);
        waitUntil(295);
        checkOutput("busy after load", int'(busy), 1);
        waitUntil(300);
        checkOutput("next tick 300", int'(duty), 300);
        waitUntil(330);
        checkOutput("reach 600", int'(duty), 600);

        // Reset in the middle of a ramp to 1000.
        applyStimulus(16'd1000);
        waitUntil(340);
        checkOutput("mid ramp 700", int'(duty), 700);
        waitUntil(345);
        pulseReset();
        checkOutput("rr duty", int'(duty), 0);
        checkOutput("rr busy", int'(busy), 0);
        checkOutput("rr atTarget", int'(atTarget), 1);
        waitUntil(3);
        checkOutput("rr old tick gone", int'(tick), 0);
        waitUntil(9);
        checkOutput("rr counter restart", int'(tick), 1);
        waitUntil(20);
        checkOutput("rr duty stays 0", int'(duty), 0);
        checkOutput("rr busy stays 0", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
